// File: rtl/product_display_pkg.sv
// product_display_pkg: shared state encoding and BCD constants for the product display path
package product_display_pkg;
  localparam int DIGIT_W = 4;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_THRESHOLD = 4'd5;
  localparam logic [DIGIT_W-1:0] BCD_ADJ_ADD = 4'd3;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_DONE = 2'd2} state_t;
endpackage

// File: rtl/bcd_digit_adjust.sv
// bcd_digit_adjust: combinational double-dabble digit fix-up; i_digit in, o_digit = i_digit+3 when >=5
module bcd_digit_adjust
  import product_display_pkg::*;
(
  input  logic [DIGIT_W-1:0] i_digit,
  output logic [DIGIT_W-1:0] o_digit
);
  assign o_digit = (i_digit >= BCD_ADJ_THRESHOLD) ? i_digit + BCD_ADJ_ADD : i_digit;
endmodule

// File: rtl/product_bcd_converter.sv
// product_bcd_converter: serial binary->BCD (clk,reset,start,inMag,inSign in; busy,done,bcdOut,signOut out)
module product_bcd_converter
  import product_display_pkg::*;
#(
  parameter int IN_WIDTH = 16,
  parameter int DIGITS = 5
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  input  logic [IN_WIDTH-1:0]     inMag,
  input  logic                    inSign,
  output logic                    busy,
  output logic                    done,
  output logic [DIGIT_W*DIGITS-1:0] bcdOut,
  output logic                    signOut
);
  localparam int AW = DIGIT_W * DIGITS;
  localparam int CW = $clog2(IN_WIDTH + 1);
  state_t r_state, w_state;
  logic [AW-1:0] r_acc, w_adj, r_bcd;
  logic [IN_WIDTH-1:0] r_bin;
  logic [CW-1:0] r_cnt;
  logic r_sgn, r_sign, w_accept, w_last;
  for (genvar i = 0; i < DIGITS; i++) begin : g_adj
    bcd_digit_adjust u_adj (
      .i_digit(r_acc[i*DIGIT_W +: DIGIT_W]),
      .o_digit(w_adj[i*DIGIT_W +: DIGIT_W])
    );
  end
  assign w_accept = start && (r_state != ST_SHIFT);
  assign w_last = (r_cnt == CW'(1));
  always_comb begin
    w_state = r_state;
    w_state = (r_state == ST_SHIFT) ? (w_last ? ST_DONE : ST_SHIFT)
                                    : (start ? ST_SHIFT : ST_IDLE);
  end
  always_ff @(posedge clk)
    if (reset) r_state <= ST_IDLE;
    else r_state <= w_state;
  always_ff @(posedge clk)
    if (reset) begin
      r_acc  <= '0;
      r_bin  <= '0;
      r_cnt  <= '0;
      r_sgn  <= 1'b0;
      r_bcd  <= '0;
      r_sign <= 1'b0;
    end else if (w_accept) begin
      r_acc <= '0;
      r_bin <= inMag;
      r_sgn <= inSign & (|inMag);
      r_cnt <= CW'(IN_WIDTH);
    end else if (r_state == ST_SHIFT) begin
      {r_acc, r_bin} <= {w_adj, r_bin} << 1;
      r_cnt <= r_cnt - 1'b1;
      if (w_last) begin
        r_bcd  <= {w_adj[AW-2:0], r_bin[IN_WIDTH-1]};
        r_sign <= r_sgn;
      end
    end
  assign busy = (r_state == ST_SHIFT);
  assign done = (r_state == ST_DONE);
  assign bcdOut = r_bcd;
  assign signOut = r_sign;
endmodule

// File: tb/tb_product_bcd_converter.sv
// tb_product_bcd_converter: randomized self-checking bench against an arithmetic decimal model
module tb_product_bcd_converter;
  logic clk = 1'b0, reset = 1'b1, start = 1'b0, inSign = 1'b0;
  logic [15:0] inMag = '0;
  logic busy, done, signOut;
  logic [19:0] bcdOut;
  int n_cmp = 0, n_bad = 0;
  logic [19:0] m_bcd = '0;
  logic m_sign = 1'b0;
  always #5 clk = ~clk;
  product_bcd_converter dut (
    .clk(clk), .reset(reset), .start(start), .inMag(inMag), .inSign(inSign),
    .busy(busy), .done(done), .bcdOut(bcdOut), .signOut(signOut)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic logic [19:0] to_bcd(input int v);
    logic [19:0] r = '0;
    for (int i = 0; i < 5; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic fire(input logic [15:0] m, input logic s);
    start = 1'b1;
    inMag = m;
    inSign = s;
    step();
    start = 1'b0;
    inMag = 16'($urandom);
    inSign = 1'($urandom);
  endtask
  task automatic finish_conv(input string tag, input logic [15:0] m, input logic s, input int inj);
    int n = 0, b = 0;
    while (!done && n < 40) begin
      b += int'(busy);
      check({tag, "/hold"}, {11'd0, signOut, bcdOut}, {11'd0, m_sign, m_bcd});
      if (n == inj) begin
        start = 1'b1;
        inMag = 16'd9999;
        inSign = ~s;
      end
      step();
      start = 1'b0;
      n++;
    end
    check({tag, "/latency"}, n, 16);
    check({tag, "/busy_cycles"}, b, 16);
    check({tag, "/done"}, {31'd0, done}, 1);
    check({tag, "/busy_at_done"}, {31'd0, busy}, 0);
    m_bcd = to_bcd(int'(m));
    m_sign = s && (m != 0);
    check({tag, "/bcd"}, {12'd0, bcdOut}, {12'd0, m_bcd});
    check({tag, "/sign"}, {31'd0, signOut}, {31'd0, m_sign});
  endtask
  task automatic conv(input string tag, input logic [15:0] m, input logic s, input int inj);
    fire(m, s);
    finish_conv(tag, m, s, inj);
    step();
    check({tag, "/done_drop"}, {31'd0, done}, 0);
  endtask
  initial begin
    int dn, r, inj;
    logic [15:0] m;
    logic s;
    step();
    step();
    reset = 1'b0;
    check("rst/busy", {31'd0, busy}, 0);
    check("rst/done", {31'd0, done}, 0);
    check("rst/bcd", {12'd0, bcdOut}, 0);
    check("rst/sign", {31'd0, signOut}, 0);
    conv("p16129", 16'd16129, 1'b1, -1);
    check("p16129/const", {12'd0, bcdOut}, 32'h16129);
    conv("zero_neg", 16'd0, 1'b1, -1);
    check("zero_neg/sign_const", {31'd0, signOut}, 0);
    conv("max", 16'd65535, 1'b0, -1);
    check("max/const", {12'd0, bcdOut}, 32'h65535);
    conv("ignore", 16'd1234, 1'b0, 5);
    check("ignore/const", {12'd0, bcdOut}, 32'h01234);
    dn = 0;
    repeat (20) begin
      dn += int'(done);
      step();
    end
    check("ignore/no_extra_done", dn, 0);
    fire(16'd4321, 1'b1);
    repeat (7) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("midrst/busy", {31'd0, busy}, 0);
    check("midrst/done", {31'd0, done}, 0);
    check("midrst/bcd", {12'd0, bcdOut}, 0);
    check("midrst/sign", {31'd0, signOut}, 0);
    m_bcd = '0;
    m_sign = 1'b0;
    conv("after_rst", 16'd7, 1'b0, -1);
    check("after_rst/const", {12'd0, bcdOut}, 32'h00007);
    fire(16'd100, 1'b0);
    finish_conv("b2b1", 16'd100, 1'b0, -1);
    start = 1'b1;
    inMag = 16'd250;
    inSign = 1'b0;
    step();
    start = 1'b0;
    check("b2b/done_drop", {31'd0, done}, 0);
    check("b2b/busy_rise", {31'd0, busy}, 1);
    finish_conv("b2b2", 16'd250, 1'b0, -1);
    check("b2b2/const", {12'd0, bcdOut}, 32'h00250);
    repeat (30) begin
      r = int'($urandom_range(0, 9));
      m = (r == 0) ? 16'd0 : (r == 1) ? 16'hFFFF : 16'($urandom);
      s = 1'($urandom);
      inj = $urandom_range(0, 1) ? int'($urandom_range(0, 15)) : -1;
      fire(m, s);
      finish_conv("rand", m, s, inj);
      if ($urandom_range(0, 1) != 0) begin
        step();
        check("rand/done_drop", {31'd0, done}, 0);
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
